// File: rtl/cpu_pkg.sv
// Shared CPU widths, reset/encoding constants and the IF/ID payload type.
package cpu_pkg;
    localparam int PC_W        = 16;
    localparam int INSTR_W     = 16;
    localparam int INSTR_BYTES = 2;
    localparam int OPC_HI      = 15;
    localparam int OPC_LO      = 12;
    localparam int OPC_W       = OPC_HI - OPC_LO + 1;

    localparam logic [PC_W-1:0]    RESET_PC    = 16'h0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR   = 16'h0000;
    localparam logic [OPC_W-1:0]   HALT_OPCODE = 4'hF;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               valid;
    } ifid_t;

    function automatic logic [OPC_W-1:0] opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction
endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: reset > flush (bubble, pc kept) > hold > load.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter logic [INSTR_W-1:0] BUBBLE_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  hold,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '{instr: BUBBLE_INSTR, pc: '0, valid: 1'b0};
        end else if (flush) begin
            q.instr <= BUBBLE_INSTR;
            q.valid <= 1'b0;
        end else if (!hold) begin
            q <= d;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, handles stall/redirect, freezes after a halt opcode.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC    = cpu_pkg::RESET_PC,
    parameter logic [OPC_W-1:0]   HALT_OPCODE = cpu_pkg::HALT_OPCODE,
    parameter logic [INSTR_W-1:0] NOP_INSTR   = cpu_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    updatedPC,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_target,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ifid_valid,
    output logic               halted
);
    typedef enum logic {RUN, HALT} state_t;

    state_t          state, state_n;
    logic [PC_W-1:0] pc, pc_n, pc_inc;
    ifid_t           ifid_d, ifid_q;
    logic            ifid_flush, ifid_hold;

    assign pc_inc = pc + PC_W'(INSTR_BYTES);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        if (state == RUN && !stall) begin
            if (opcode(instruction) == HALT_OPCODE) state_n = HALT;
            else                                    pc_n    = pc_inc;
        end
        // redirect beats stall and also unfreezes a wrong-path halt
        if (redirect) begin
            pc_n    = {redirect_target[PC_W-1:1], 1'b0};
            state_n = RUN;
        end
    end

    // while halted the register drains to bubbles, but a stall still holds it
    assign ifid_flush = redirect || (state == HALT && !stall);
    assign ifid_hold  = stall;
    assign ifid_d     = '{instr: instruction, pc: pc_inc, valid: 1'b1};

    ifid_reg #(.BUBBLE_INSTR(NOP_INSTR)) u_ifid (
        .clk  (clk),
        .reset(reset),
        .hold (ifid_hold),
        .flush(ifid_flush),
        .d    (ifid_d),
        .q    (ifid_q)
    );

    assign updatedPC  = pc;
    assign ifid_instr = ifid_q.instr;
    assign ifid_pc    = ifid_q.pc;
    assign ifid_valid = ifid_q.valid;
    assign halted     = (state == HALT);
endmodule
